layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
Top-level scheduler for the MNIST inference datapath. Walks a programmable table of layer descriptors and launches the conv, max-pool or dense engine for each layer with that layer's addresses and sizes. Owns the single shared feature-map SRAM and grants it to the active engine only. Reports completion, or a watchdog error if an engine never finishes.

Parameters:
MAX_LAYERS, 4, descriptor table depth
ADDR_W, 12, SRAM address width
DATA_W, 16, SRAM data width (signed)
DIM_W, 6, row/column size width
TIMEOUT, 65535, max WAIT cycles per layer before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
run  in  1  start pulse; sampled only in IDLE
num_layers  in  3  layers to execute (1..MAX_LAYERS), sampled with run
cfg_we  in  1  descriptor write strobe
cfg_idx  in  2  descriptor index
cfg_desc  in  50  {eng_id[1:0], src_addr[11:0], dst_addr[11:0], src_rows, src_cols, out_rows, out_cols (6b each)}
busy  out  1  high from run accept until DONE or ERR
all_done  out  1  high in DONE until next run or reset
error  out  1  high in ERR until next run or reset
cur_layer  out  2  index of layer in progress
eng_reset  out  3  one-hot engine reset
eng_start  out  3  one-hot engine start
eng_done  in  3  per-engine done level
eng_src_addr, eng_dst_addr  out  12 each  broadcast descriptor fields
eng_src_rows, eng_src_cols, eng_out_rows, eng_out_cols  out  6 each  broadcast descriptor fields
eng_rd_addr  in  3x12  per-engine read address
eng_wr_addr  in  3x12  per-engine write address
eng_wr_data  in  3x16  per-engine write data
eng_wr_en  in  3  per-engine write enable
mem_rd_addr, mem_wr_addr  out  12 each  SRAM port
mem_wr_data  out  16  SRAM write data
mem_wr_en  out  1  SRAM write enable; SRAM read data goes straight to all engines

Behaviour:
- Reset: state IDLE; busy, all_done, error, eng_reset, eng_start, cur_layer = 0; descriptor table cleared to 0; mem_wr_en = 0.
- IDLE: run=1 and num_layers in 1..MAX_LAYERS -> cur_layer=0, clear all_done/error, busy=1, go to LOAD. num_layers=0 or >MAX_LAYERS -> error=1, stay IDLE.
- LOAD (1 cycle): latch table[cur_layer] into registered eng_* fields; assert eng_reset[eng_id] for this cycle only, because engines hold done until reset. -> START.
- START (1 cycle): eng_start[eng_id]=1 for exactly this cycle; clear watchdog. -> WAIT.
- WAIT: eng_done[eng_id]=1 -> NEXT. Watchdog reaching TIMEOUT -> ERR. Done from non-active engines is ignored.
- NEXT (1 cycle): if cur_layer == num_layers-1 -> DONE, else cur_layer+1 -> LOAD.
- DONE: all_done=1, busy=0; run is accepted as in IDLE.
- ERR: error=1, busy=0, all engines held in eng_reset; run is accepted as in IDLE.
- eng_id=3 (unused) in LOAD -> ERR the following cycle; no start is issued.
- SRAM mux: combinational from registered active id. In START/WAIT, mem_* takes the active engine's signals. Otherwise mem_wr_en=0 and the addresses are 0. Writes from inactive engines are dropped.
- cfg_we while busy is ignored. cfg_we with run in the same IDLE cycle: write first; the run uses the updated table.
- run while busy is ignored. Reset mid-layer aborts immediately; the table is cleared.
- Layer-to-layer overhead is 3 cycles (NEXT, LOAD, START).

Decomposition:
- Package layer_pkg:
  - ENG_CONV=0, ENG_POOL=1, ENG_DENSE=2
  - layer_desc_t packed struct plus its field widths
  - state enum
- Sub-module sram_port_mux: one-hot/indexed mux of the engine SRAM ports with write gating.

Test Plan:
- Program 3 layers (conv: src 0x000 28x28 -> dst 0x400 24x24; pool: 0x400 24x24 -> 0x800 12x12; dense: 0x800 -> 0xA00), run with num_layers=3, engine models done after 50 cycles -> eng_start pulses 0,1,2 in order, cur_layer 0->1->2, all_done after last done + 1 cycle.
- Pool model writes at 0x805 with value 0x7FFF while conv model also drives wr_en -> only the pool write reaches the SRAM.
- Engine never asserts done, TIMEOUT=100 -> error=1 exactly 100 WAIT cycles after start, busy=0, eng_reset held.
- run with num_layers=0 -> error=1, no eng_start. Descriptor with eng_id=3 -> ERR, no start.
- Assert reset during WAIT of layer 1 -> next cycle all outputs are at reset values and the table is cleared. cfg_we during busy -> table unchanged.
- After DONE, reprogram layer 0 and run again -> eng_reset pulses before start, and a stale done level does not skip WAIT.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types for the layer sequencer: engine ids, the layer descriptor and the FSM states.
// Pure declarations; no latency and no flow control of its own.
package layer_pkg;

    localparam int ENG_ID_W  = 2;
    localparam int ADDR_F_W  = 12;
    localparam int DIM_F_W   = 6;
    localparam int NUM_ENG   = 3;

    localparam logic [ENG_ID_W-1:0] ENG_CONV  = 2'd0;
    localparam logic [ENG_ID_W-1:0] ENG_POOL  = 2'd1;
    localparam logic [ENG_ID_W-1:0] ENG_DENSE = 2'd2;

    typedef struct packed {
        logic [ENG_ID_W-1:0] eng_id;
        logic [ADDR_F_W-1:0] src_addr;
        logic [ADDR_F_W-1:0] dst_addr;
        logic [DIM_F_W-1:0]  src_rows;
        logic [DIM_F_W-1:0]  src_cols;
        logic [DIM_F_W-1:0]  out_rows;
        logic [DIM_F_W-1:0]  out_cols;
    } layer_desc_t;

    localparam int DESC_W = $bits(layer_desc_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_t;

    // Id 3 is not an engine and maps to no select line at all.
    function automatic logic [NUM_ENG-1:0] eng_onehot(input logic [ENG_ID_W-1:0] id);
        case (id)
            ENG_CONV:  return 3'b001;
            ENG_POOL:  return 3'b010;
            ENG_DENSE: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Selects one engine's SRAM read/write port onto the shared SRAM; purely combinational.
// Unselected engines, or a disabled mux, see their writes dropped and the SRAM sees address 0.
module sram_port_mux #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                en,
    input  logic [1:0]          sel,
    input  logic [3*ADDR_W-1:0] eng_rd_addr,
    input  logic [3*ADDR_W-1:0] eng_wr_addr,
    input  logic [3*DATA_W-1:0] eng_wr_data,
    input  logic [2:0]          eng_wr_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic                mem_wr_en
);

    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (en && sel == 2'(i)) begin
                mem_rd_addr = eng_rd_addr[i*ADDR_W +: ADDR_W];
                mem_wr_addr = eng_wr_addr[i*ADDR_W +: ADDR_W];
                mem_wr_data = eng_wr_data[i*DATA_W +: DATA_W];
                mem_wr_en   = eng_wr_en[i];
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks the layer descriptor table, resets/starts one engine per layer and owns the shared SRAM port.
// 3 cycles of overhead between layers (NEXT, LOAD, START); a watchdog aborts a layer whose engine never reports done.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int MAX_LAYERS = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int DIM_W      = 6,
    parameter int TIMEOUT    = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [2:0]          num_layers,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_idx,
    input  logic [DESC_W-1:0]   cfg_desc,
    output logic                busy,
    output logic                all_done,
    output logic                error,
    output logic [1:0]          cur_layer,
    output logic [2:0]          eng_reset,
    output logic [2:0]          eng_start,
    input  logic [2:0]          eng_done,
    output logic [ADDR_W-1:0]   eng_src_addr,
    output logic [ADDR_W-1:0]   eng_dst_addr,
    output logic [DIM_W-1:0]    eng_src_rows,
    output logic [DIM_W-1:0]    eng_src_cols,
    output logic [DIM_W-1:0]    eng_out_rows,
    output logic [DIM_W-1:0]    eng_out_cols,
    input  logic [3*ADDR_W-1:0] eng_rd_addr,
    input  logic [3*ADDR_W-1:0] eng_wr_addr,
    input  logic [3*DATA_W-1:0] eng_wr_data,
    input  logic [2:0]          eng_wr_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic                mem_wr_en
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]      MAX_L   = 3'(MAX_LAYERS);

    state_t            state, state_nxt;
    layer_desc_t       table_q [MAX_LAYERS];
    layer_desc_t       act_q;
    layer_desc_t       cur_desc;
    logic [1:0]        cur_q;
    logic [2:0]        num_q;
    logic              err_flag;
    logic [WD_W-1:0]   wd_q;
    logic              idle_like;
    logic              run_ok;
    logic              last_layer;
    logic              act_done;

    assign cur_desc   = table_q[cur_q];
    assign idle_like  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign run_ok     = (num_layers != 3'd0) && (num_layers <= MAX_L);
    assign last_layer = ({1'b0, cur_q} == (num_q - 3'd1));
    assign act_done   = (eng_done & eng_onehot(act_q.eng_id)) != 3'b000;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (run) state_nxt = run_ok ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD:  state_nxt = (cur_desc.eng_id == 2'd3) ? ST_ERR : ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (act_done)             state_nxt = ST_NEXT;
                else if (wd_q == WD_LAST) state_nxt = ST_ERR;
            end
            ST_NEXT:  state_nxt = last_layer ? ST_DONE : ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The table only changes between jobs; a write alongside run lands before LOAD reads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LAYERS; i++) table_q[i] <= '0;
            act_q    <= '0;
            cur_q    <= '0;
            num_q    <= '0;
            err_flag <= 1'b0;
            wd_q     <= '0;
        end else begin
            if (cfg_we && idle_like) table_q[cfg_idx] <= layer_desc_t'(cfg_desc);
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (run && run_ok) begin
                        cur_q    <= '0;
                        num_q    <= num_layers;
                        err_flag <= 1'b0;
                    end else if (run) begin
                        err_flag <= 1'b1;
                    end
                end
                ST_LOAD:  act_q <= cur_desc;
                ST_START: wd_q  <= '0;
                ST_WAIT:  wd_q  <= wd_q + 1'b1;
                ST_NEXT:  if (!last_layer) cur_q <= cur_q + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state == ST_LOAD) || (state == ST_START) ||
                    (state == ST_WAIT) || (state == ST_NEXT);
        all_done  = (state == ST_DONE);
        error     = (state == ST_ERR) || err_flag;
        eng_reset = 3'b000;
        eng_start = 3'b000;
        case (state)
            ST_LOAD:  eng_reset = eng_onehot(cur_desc.eng_id);
            ST_START: eng_start = eng_onehot(act_q.eng_id);
            ST_ERR:   eng_reset = 3'b111;
            default: ;
        endcase
    end

    assign cur_layer    = cur_q;
    assign eng_src_addr = act_q.src_addr;
    assign eng_dst_addr = act_q.dst_addr;
    assign eng_src_rows = act_q.src_rows;
    assign eng_src_cols = act_q.src_cols;
    assign eng_out_rows = act_q.out_rows;
    assign eng_out_cols = act_q.out_cols;

    sram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .en          ((state == ST_START) || (state == ST_WAIT)),
        .sel         (act_q.eng_id),
        .eng_rd_addr (eng_rd_addr),
        .eng_wr_addr (eng_wr_addr),
        .eng_wr_data (eng_wr_data),
        .eng_wr_en   (eng_wr_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with behavioural engines that raise done LAT cycles after start.
module tb_layer_sequencer;

    localparam int LAT = 50;

    logic        clk = 1'b0;
    logic        reset, run, cfg_we;
    logic [2:0]  num_layers;
    logic [1:0]  cfg_idx;
    logic [49:0] cfg_desc;
    logic        busy, all_done, error;
    logic [1:0]  cur_layer;
    logic [2:0]  eng_reset, eng_start;
    logic [2:0]  eng_done = 3'b000;
    logic [11:0] eng_src_addr, eng_dst_addr;
    logic [5:0]  eng_src_rows, eng_src_cols, eng_out_rows, eng_out_cols;
    logic [35:0] eng_rd_addr, eng_wr_addr;
    logic [47:0] eng_wr_data;
    logic [2:0]  eng_wr_en;
    logic [11:0] mem_rd_addr, mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_en;

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  hang = 3'b000;
    int          cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    layer_sequencer #(.TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .run(run), .num_layers(num_layers),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_desc(cfg_desc),
        .busy(busy), .all_done(all_done), .error(error), .cur_layer(cur_layer),
        .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
        .eng_src_addr(eng_src_addr), .eng_dst_addr(eng_dst_addr),
        .eng_src_rows(eng_src_rows), .eng_src_cols(eng_src_cols),
        .eng_out_rows(eng_out_rows), .eng_out_cols(eng_out_cols),
        .eng_rd_addr(eng_rd_addr), .eng_wr_addr(eng_wr_addr),
        .eng_wr_data(eng_wr_data), .eng_wr_en(eng_wr_en),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en)
    );

    // Engines hold done until their reset line is pulsed.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (eng_reset[i]) begin
                eng_done[i] <= 1'b0;
                cnt[i]      <= 0;
            end else if (eng_start[i]) begin
                cnt[i] <= hang[i] ? 0 : LAT;
            end else if (cnt[i] > 1) begin
                cnt[i] <= cnt[i] - 1;
            end else if (cnt[i] == 1) begin
                cnt[i]      <= 0;
                eng_done[i] <= 1'b1;
            end
        end
    end

    function automatic logic [49:0] mk(input logic [1:0] e, input logic [11:0] s, input logic [11:0] d,
                                       input logic [5:0] sr, input logic [5:0] sc,
                                       input logic [5:0] orr, input logic [5:0] oc);
        return {e, s, d, sr, sc, orr, oc};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic write_desc(input logic [1:0] idx, input logic [49:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_desc = d;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic [2:0] n);
        run = 1'b1; num_layers = n;
        tick;
        run = 1'b0;
    endtask

    task automatic wait_start(input logic [2:0] m, input int budget, output int k);
        k = -1;
        for (int i = 0; i < budget && k < 0; i++) begin
            if ((eng_start & m) != 3'b000) k = i;
            else tick;
        end
    endtask

    task automatic wait_all_done(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget && k < 0; i++) begin
            tick;
            if (all_done) k = i;
        end
    endtask

    task automatic program_three;
        write_desc(2'd0, mk(2'd0, 12'h000, 12'h400, 6'd28, 6'd28, 6'd24, 6'd24));
        write_desc(2'd1, mk(2'd1, 12'h400, 12'h800, 6'd24, 6'd24, 6'd12, 6'd12));
        write_desc(2'd2, mk(2'd2, 12'h800, 12'hA00, 6'd12, 6'd12, 6'd1,  6'd10));
    endtask

    task automatic test_reset;
        reset = 1'b1; run = 1'b0; num_layers = 3'd0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_desc = '0;
        eng_rd_addr = '0; eng_wr_addr = '0; eng_wr_data = '0; eng_wr_en = 3'b000;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        checks++;
        if ({busy, all_done, error, cur_layer, eng_reset, eng_start, mem_wr_en} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {busy, all_done, error, cur_layer, eng_reset, eng_start, mem_wr_en});
        end
        checks++;
        if ({mem_rd_addr, mem_wr_addr, eng_src_addr, eng_dst_addr} !== 48'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", {mem_rd_addr, mem_wr_addr, eng_src_addr, eng_dst_addr});
        end
    endtask

    task automatic test_three_layers;
        logic [11:0] e_src [3];
        logic [11:0] e_dst [3];
        logic [5:0]  e_sr  [3];
        logic [5:0]  e_oc  [3];
        int st_cyc [3], st_id [3], st_lay [3], dn_cyc [3];
        logic [11:0] st_src [3], st_dst [3];
        logic [5:0]  st_sr [3], st_oc [3];
        logic [2:0]  rst_before [3];
        logic [2:0]  prev_rst, prev_done;
        int nstart = 0, ndone = 0, start_cycles = 0, ad_cyc = -1;
        e_src = '{12'h000, 12'h400, 12'h800};
        e_dst = '{12'h400, 12'h800, 12'hA00};
        e_sr  = '{6'd28, 6'd24, 6'd12};
        e_oc  = '{6'd24, 6'd12, 6'd10};
        program_three;
        start_run(3'd3);
        prev_rst = eng_reset; prev_done = eng_done;
        for (int k = 2; k <= 400 && ad_cyc < 0; k++) begin
            tick;
            if (eng_start != 3'b000) begin
                start_cycles++;
                if (nstart < 3) begin
                    st_cyc[nstart] = k; st_lay[nstart] = int'(cur_layer);
                    st_id[nstart] = (eng_start == 3'b001) ? 0 : (eng_start == 3'b010) ? 1 : (eng_start == 3'b100) ? 2 : 9;
                    st_src[nstart] = eng_src_addr; st_dst[nstart] = eng_dst_addr;
                    st_sr[nstart] = eng_src_rows; st_oc[nstart] = eng_out_cols;
                    rst_before[nstart] = prev_rst;
                    nstart++;
                end
            end
            if (ndone < nstart && st_id[ndone] < 3 && eng_done[st_id[ndone]] && !prev_done[st_id[ndone]]) begin
                dn_cyc[ndone] = k; ndone++;
            end
            if (all_done) ad_cyc = k;
            prev_rst = eng_reset; prev_done = eng_done;
        end
        checks++;
        if (ad_cyc < 0 || nstart != 3 || ndone != 3 || start_cycles != 3) begin
            errors++;
            $display("FAIL seq_progress: got starts %0d dones %0d start_cycles %0d all_done_cyc %0d want 3 3 3 >0",
                     nstart, ndone, start_cycles, ad_cyc);
        end else begin
            checks++;
            if (st_cyc[0] != 2) begin
                errors++; $display("FAIL first_start_latency: got %0d want 2", st_cyc[0]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (st_id[i] != i || st_lay[i] != i || rst_before[i] !== 3'(1 << i)) begin
                    errors++;
                    $display("FAIL layer%0d_order: got eng %0d layer %0d prior_rst %b want %0d %0d %b",
                             i, st_id[i], st_lay[i], rst_before[i], i, i, 3'(1 << i));
                end
                checks++;
                if (st_src[i] !== e_src[i] || st_dst[i] !== e_dst[i] || st_sr[i] !== e_sr[i] || st_oc[i] !== e_oc[i]) begin
                    errors++;
                    $display("FAIL layer%0d_fields: got %h %h %0d %0d want %h %h %0d %0d", i,
                             st_src[i], st_dst[i], st_sr[i], st_oc[i], e_src[i], e_dst[i], e_sr[i], e_oc[i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (st_cyc[i+1] != dn_cyc[i] + 3) begin
                    errors++; $display("FAIL overhead%0d: got %0d want %0d", i, st_cyc[i+1], dn_cyc[i] + 3);
                end
            end
            checks++;
            if (ad_cyc != dn_cyc[2] + 2 || busy !== 1'b0 || error !== 1'b0) begin
                errors++;
                $display("FAIL done_timing: got cyc %0d busy %b err %b want %0d 0 0", ad_cyc, busy, error, dn_cyc[2] + 2);
            end
        end
    endtask

    task automatic test_sram_mux;
        int k;
        program_three;
        eng_rd_addr = {12'h000, 12'h456, 12'h321};
        eng_wr_addr = {12'h000, 12'h805, 12'h123};
        eng_wr_data = {16'h0000, 16'h7FFF, 16'h1111};
        start_run(3'd2);
        wait_start(3'b001, 10, k);
        tick;
        eng_wr_en = 3'b010; #1;
        checks++;
        if (k < 0 || mem_wr_en !== 1'b0 || mem_rd_addr !== 12'h321) begin
            errors++; $display("FAIL mux_drop_inactive: got wr_en %b rd %h want 0 321", mem_wr_en, mem_rd_addr);
        end
        eng_wr_en = 3'b011; #1;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 12'h123 || mem_wr_data !== 16'h1111) begin
            errors++; $display("FAIL mux_conv: got %b %h %h want 1 123 1111", mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        wait_start(3'b010, 200, k);
        tick;
        checks++;
        if (k < 0 || mem_wr_en !== 1'b1 || mem_wr_addr !== 12'h805 || mem_wr_data !== 16'h7FFF || mem_rd_addr !== 12'h456) begin
            errors++;
            $display("FAIL mux_pool: got %b %h %h rd %h want 1 805 7fff 456", mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr);
        end
        wait_all_done(200, k);
        checks++;
        if (k < 0 || mem_wr_en !== 1'b0 || mem_wr_addr !== 12'h000 || mem_rd_addr !== 12'h000) begin
            errors++; $display("FAIL mux_idle: got %b %h %h k %0d want 0 0 0", mem_wr_en, mem_wr_addr, mem_rd_addr, k);
        end
        eng_wr_en = 3'b000;
    endtask

    task automatic test_timeout;
        int k;
        hang = 3'b001;
        write_desc(2'd0, mk(2'd0, 12'h000, 12'h400, 6'd28, 6'd28, 6'd24, 6'd24));
        start_run(3'd1);
        wait_start(3'b001, 10, k);
        repeat (100) tick;
        checks++;
        if (k < 0 || error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got err %b busy %b k %0d want 0 1", error, busy, k);
        end
        tick;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || eng_reset !== 3'b111 || eng_start !== 3'b000) begin
            errors++; $display("FAIL timeout_err: got %b %b %b %b want 1 0 111 000", error, busy, eng_reset, eng_start);
        end
        hang = 3'b000;
    endtask

    task automatic test_bad_run;
        int seen = 0;
        start_run(3'd0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || eng_reset !== 3'b000) begin
            errors++; $display("FAIL run_zero: got err %b busy %b rst %b want 1 0 000", error, busy, eng_reset);
        end
        repeat (4) begin tick; if (eng_start != 3'b000) seen++; end
        start_run(3'd5);
        repeat (3) begin tick; if (eng_start != 3'b000) seen++; end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || seen != 0) begin
            errors++; $display("FAIL run_too_many: got err %b busy %b starts %0d want 1 0 0", error, busy, seen);
        end
    endtask

    task automatic test_bad_eng_id;
        int seen = 0;
        write_desc(2'd0, mk(2'd3, 12'h010, 12'h020, 6'd4, 6'd4, 6'd4, 6'd4));
        start_run(3'd1);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || eng_reset !== 3'b000) begin
            errors++; $display("FAIL bad_id_load: got err %b busy %b rst %b want 0 1 000", error, busy, eng_reset);
        end
        tick;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_id_err: got err %b busy %b want 1 0", error, busy);
        end
        repeat (5) begin tick; if (eng_start != 3'b000) seen++; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL bad_id_nostart: got %0d starts want 0", seen);
        end
    endtask

    task automatic test_reset_mid_layer;
        int k;
        program_three;
        start_run(3'd3);
        wait_start(3'b010, 200, k);
        repeat (5) tick;
        reset = 1'b1;
        tick;
        checks++;
        if (k < 0 || {busy, all_done, error, cur_layer, eng_reset, eng_start, mem_wr_en} !== 12'd0 || eng_dst_addr !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: got %b dst %h k %0d want 0 0", {busy, all_done, error, cur_layer, eng_reset, eng_start, mem_wr_en}, eng_dst_addr, k);
        end
        reset = 1'b0;
        start_run(3'd1);
        checks++;
        if (eng_reset !== 3'b001) begin
            errors++; $display("FAIL cleared_load: got rst %b want 001", eng_reset);
        end
        tick;
        checks++;
        if (eng_start !== 3'b001 || eng_dst_addr !== 12'h000 || eng_src_rows !== 6'd0 || eng_out_cols !== 6'd0) begin
            errors++;
            $display("FAIL table_cleared: got %b %h %0d %0d want 001 000 0 0", eng_start, eng_dst_addr, eng_src_rows, eng_out_cols);
        end
        wait_all_done(200, k);
    endtask

    task automatic test_cfg_while_busy;
        int k;
        program_three;
        start_run(3'd2);
        write_desc(2'd1, mk(2'd2, 12'h777, 12'h111, 6'd1, 6'd1, 6'd1, 6'd1));
        start_run(3'd0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL run_while_busy: got err %b busy %b want 0 1", error, busy);
        end
        wait_all_done(300, k);
        start_run(3'd2);
        wait_start(3'b010, 200, k);
        checks++;
        if (k < 0 || eng_src_addr !== 12'h400 || eng_dst_addr !== 12'h800) begin
            errors++; $display("FAIL cfg_busy_ignored: got src %h dst %h k %0d want 400 800", eng_src_addr, eng_dst_addr, k);
        end
        wait_all_done(200, k);
    endtask

    task automatic test_back_to_back_rerun;
        int k;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_desc = mk(2'd0, 12'h000, 12'h555, 6'd28, 6'd28, 6'd24, 6'd24);
        run = 1'b1; num_layers = 3'd1;
        tick;
        cfg_we = 1'b0; run = 1'b0;
        checks++;
        if (eng_reset !== 3'b001 || eng_start !== 3'b000 || all_done !== 1'b0) begin
            errors++; $display("FAIL rerun_load: got rst %b start %b done %b want 001 000 0", eng_reset, eng_start, all_done);
        end
        tick;
        checks++;
        if (eng_start !== 3'b001 || eng_dst_addr !== 12'h555) begin
            errors++; $display("FAIL rerun_start: got %b %h want 001 555", eng_start, eng_dst_addr);
        end
        wait_all_done(200, k);
        checks++;
        if (k != LAT + 3) begin
            errors++; $display("FAIL stale_done: got all_done after %0d want %0d", k, LAT + 3);
        end
    endtask

    initial begin
        test_reset;
        test_three_layers;
        test_sram_mux;
        test_timeout;
        test_bad_run;
        test_bad_eng_id;
        test_reset_mid_layer;
        test_cfg_while_busy;
        test_back_to_back_rerun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
